// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors and line levels.
// Intended for both the transmitter and the matching receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN    = 1'b0;
    localparam logic PAR_ODD     = 1'b1;
    localparam logic TX_IDLE_LVL = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Per-bit clock divider: flags the last cycle of a serial bit and the cycle just before it.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic bit_end,
    output logic pre_end_c
);

    localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned LAST = CLKS_PER_BIT - 1;
    localparam int unsigned PRE  = (CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0;

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = bit_end ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bit_end = (count_q == CW'(LAST));
    // With one cycle per bit every cycle is both the last and the one before a bit end.
    assign pre_end_c = (CLKS_PER_BIT == 1) ? 1'b1 : (!bit_end && (count_q == CW'(PRE)));

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, LSB-first data, optional parity, 1 or 2 stop bits,
// gapless back-to-back frames and a frame-done pulse in the final stop-bit cycle.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned   IW        = $clog2(DATA_WIDTH);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
        $error("uart_tx_param: DATA_WIDTH must be 5..9");
    end

    uart_state_e           state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  stop_q, stop_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  accept_c;
    logic                  bit_end;
    logic                  pre_end_c;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .CLK      (CLK),
        .RST      (RST),
        .clr      (accept_c),
        .en       (state_q != IDLE),
        .bit_end  (bit_end),
        .pre_end_c(pre_end_c)
    );

    // Next state, latched frame config and the registered line/status values.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        stop_d       = stop_q;
        data_d       = data_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        tx_d         = TX_IDLE_LVL;
        busy_d       = 1'b0;
        frame_done_d = 1'b0;
        accept_c     = Data_valid && ((state_q == IDLE) || frame_done_q);

        case (state_q)
            IDLE: ;
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_q == STOP_LAST) begin
                        stop_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept_c) begin
            state_d   = START;
            idx_d     = '0;
            stop_d    = 1'b0;
            data_d    = P_DATA;
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[idx_d];
            PARITY:  tx_d = (^data_d) ^ (par_typ_d == PAR_ODD);
            default: tx_d = TX_IDLE_LVL;
        endcase

        busy_d = (state_d != IDLE);
        // Registered pulse: raise it one cycle ahead so it lands on the final stop-bit cycle.
        frame_done_d = (state_d == STOP) && (stop_d == STOP_LAST) && pre_end_c;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            stop_q       <= 1'b0;
            data_q       <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            tx_q         <= TX_IDLE_LVL;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            stop_q       <= stop_d;
            data_q       <= data_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign TX_OUT     = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations, each with a per-cycle scoreboard of
// expected {TX_OUT, busy, frame_done} built from a serial reference model.
module tb_uart_tx_param;

    localparam int DW_T  [3] = '{8, 8, 5};
    localparam int CPB_T [3] = '{4, 4, 1};
    localparam int SB_T  [3] = '{1, 2, 1};

    logic       clk;
    logic [2:0] rst, dv, pen, ptyp, tx, busy, fd;
    logic [7:0] pd0, pd1;
    logic [4:0] pd2;

    logic [2:0] q0[$];
    logic [2:0] q1[$];
    logic [2:0] q2[$];

    int n_total, n_bad;
    int busy_cnt [3];
    int fd_cnt   [3];
    int acc_cnt  [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_param #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) u_a (
        .CLK(clk), .RST(rst[0]), .P_DATA(pd0), .Data_valid(dv[0]), .PAR_EN(pen[0]),
        .PAR_TYP(ptyp[0]), .TX_OUT(tx[0]), .busy(busy[0]), .frame_done(fd[0]));

    uart_tx_param #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) u_b (
        .CLK(clk), .RST(rst[1]), .P_DATA(pd1), .Data_valid(dv[1]), .PAR_EN(pen[1]),
        .PAR_TYP(ptyp[1]), .TX_OUT(tx[1]), .busy(busy[1]), .frame_done(fd[1]));

    uart_tx_param #(.DATA_WIDTH(5), .CLKS_PER_BIT(1), .STOP_BITS(1)) u_c (
        .CLK(clk), .RST(rst[2]), .P_DATA(pd2), .Data_valid(dv[2]), .PAR_EN(pen[2]),
        .PAR_TYP(ptyp[2]), .TX_OUT(tx[2]), .busy(busy[2]), .frame_done(fd[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit sb_empty(input int i);
        case (i)
            0:       return q0.size() == 0;
            1:       return q1.size() == 0;
            default: return q2.size() == 0;
        endcase
    endfunction

    function automatic logic [2:0] sb_front(input int i);
        case (i)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic sb_push(input int i, input logic [2:0] v);
        case (i)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic sb_pop(input int i);
        logic [2:0] dummy;
        case (i)
            0:       dummy = q0.pop_front();
            1:       dummy = q1.pop_front();
            default: dummy = q2.pop_front();
        endcase
    endtask

    task automatic sb_clear(input int i);
        case (i)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    function automatic int cur_data(input int i);
        case (i)
            0:       return int'(pd0);
            1:       return int'(pd1);
            default: return int'(pd2);
        endcase
    endfunction

    // Reference serial model: one entry {tx, busy, frame_done} per clock cycle of the frame.
    task automatic push_frame(input int i, input int data, input bit pe, input bit pt);
        int cpb;
        int nstop;
        bit par;
        bit b;
        cpb   = CPB_T[i];
        nstop = SB_T[i] * cpb;
        par   = pt;
        for (int n = 0; n < cpb; n++) sb_push(i, 3'b010);
        for (int k = 0; k < DW_T[i]; k++) begin
            b   = bit'((data >> k) & 1);
            par = par ^ b;
            for (int n = 0; n < cpb; n++) sb_push(i, {b, 2'b10});
        end
        if (pe) begin
            for (int n = 0; n < cpb; n++) sb_push(i, {par, 2'b10});
        end
        for (int n = 0; n < nstop; n++) sb_push(i, {2'b11, n == nstop - 1});
    endtask

    // Compare all three DUTs for the current cycle, then advance one clock.
    task automatic cycle();
        for (int i = 0; i < 3; i++) begin
            logic [2:0] exp;
            bit         idle;
            string      tag;
            idle = sb_empty(i);
            exp  = idle ? 3'b100 : sb_front(i);
            tag  = (i == 0) ? "line_a" : (i == 1) ? "line_b" : "line_c";
            chk(tag, 32'({tx[i], busy[i], fd[i]}), 32'(exp));
            if (busy[i] === 1'b1) busy_cnt[i]++;
            if (fd[i] === 1'b1) fd_cnt[i]++;
            if (!idle) sb_pop(i);
            if (rst[i]) begin
                sb_clear(i);
            end else if (dv[i] && (idle || exp[0])) begin
                push_frame(i, cur_data(i), pen[i], ptyp[i]);
                acc_cnt[i]++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < 3; i++) begin
            busy_cnt[i] = 0;
            fd_cnt[i]   = 0;
            acc_cnt[i]  = 0;
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        clr_cnt();
        rst  = 3'b111;
        dv   = 3'b000;
        pen  = 3'b000;
        ptyp = 3'b000;
        pd0  = 8'h00;
        pd1  = 8'h00;
        pd2  = 5'h00;
        @(posedge clk);
        @(negedge clk);
        cycle();
        rst = 3'b000;
        run(2);

        // Single frame, no parity.
        clr_cnt();
        pd0 = 8'hA5; dv[0] = 1'b1;
        cycle();
        dv[0] = 1'b0;
        run(44);
        chk("t1_busy_len", 32'(busy_cnt[0]), 32'd40);
        chk("t1_fd_cnt", 32'(fd_cnt[0]), 32'd1);

        // Parity even then odd; inputs disturbed mid-frame.
        for (int pt = 0; pt < 2; pt++) begin
            clr_cnt();
            pd0 = 8'h03; pen[0] = 1'b1; ptyp[0] = 1'(pt); dv[0] = 1'b1;
            cycle();
            dv[0] = 1'b0; pd0 = 8'hFF; ptyp[0] = ~1'(pt); pen[0] = 1'b0;
            run(36);
            chk("t2_parity_bit", 32'(tx[0]), 32'(pt));
            run(12);
            chk("t2_busy_len", 32'(busy_cnt[0]), 32'd44);
            chk("t2_fd_cnt", 32'(fd_cnt[0]), 32'd1);
        end

        // Two stop bits, Data_valid held high across two frames.
        clr_cnt();
        pd1 = 8'h00; dv[1] = 1'b1;
        cycle();
        pd1 = 8'hFF;
        for (int n = 0; n < 200 && acc_cnt[1] < 2; n++) cycle();
        dv[1] = 1'b0;
        run(50);
        chk("t3_accepts", 32'(acc_cnt[1]), 32'd2);
        chk("t3_busy_len", 32'(busy_cnt[1]), 32'd88);
        chk("t3_fd_cnt", 32'(fd_cnt[1]), 32'd2);

        // Data_valid during DATA is ignored.
        clr_cnt();
        pd0 = 8'h5A; dv[0] = 1'b1;
        cycle();
        dv[0] = 1'b0;
        run(15);
        pd0 = 8'h99; dv[0] = 1'b1;
        cycle();
        dv[0] = 1'b0;
        run(30);
        chk("t4_accepts", 32'(acc_cnt[0]), 32'd1);
        chk("t4_busy_len", 32'(busy_cnt[0]), 32'd40);
        chk("t4_idle", 32'({tx[0], busy[0]}), 32'd2);

        // Reset in the middle of DATA, then a clean frame.
        clr_cnt();
        pd0 = 8'h3C; dv[0] = 1'b1;
        cycle();
        dv[0] = 1'b0;
        run(16);
        rst[0] = 1'b1;
        cycle();
        rst[0] = 1'b0;
        chk("t5_tx_after_rst", 32'(tx[0]), 32'd1);
        chk("t5_busy_after_rst", 32'(busy[0]), 32'd0);
        run(40);
        chk("t5_no_fd", 32'(fd_cnt[0]), 32'd0);
        clr_cnt();
        pd0 = 8'hC3; dv[0] = 1'b1;
        cycle();
        dv[0] = 1'b0;
        run(44);
        chk("t5_fd_after", 32'(fd_cnt[0]), 32'd1);
        chk("t5_busy_after", 32'(busy_cnt[0]), 32'd40);

        // One cycle per bit, 5 data bits with parity, gapless back-to-back frames.
        clr_cnt();
        pen[2] = 1'b1; pd2 = 5'($urandom); ptyp[2] = 1'($urandom); dv[2] = 1'b1;
        for (int n = 0; n < 200 && acc_cnt[2] < 4; n++) begin
            int prev;
            prev = acc_cnt[2];
            cycle();
            if (acc_cnt[2] != prev) begin
                pd2     = 5'($urandom);
                ptyp[2] = 1'($urandom);
            end
        end
        dv[2] = 1'b0;
        run(12);
        chk("t6_accepts", 32'(acc_cnt[2]), 32'd4);
        chk("t6_busy_len", 32'(busy_cnt[2]), 32'd32);
        chk("t6_fd_cnt", 32'(fd_cnt[2]), 32'd4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
